fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_pkg.sv | 16 +
 rtl/fetch_buffer.sv | 67 ++++++
 rtl/fetch_unit.sv | 121 ++++++++++++
 tb/tb_fetch_unit.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared defaults and the fetch FSM state type for the instruction prefetcher.
// No ports; imported by fetch_buffer and fetch_unit.
package fetch_pkg;

    localparam int AW_DEF    = 8;
    localparam int DW_DEF    = 8;
    localparam int DEPTH_DEF = 2;

    // IDLE: no request; WAIT: request whose data is kept; DROP: request whose data is discarded.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } state_t;

endpackage

// File: rtl/fetch_buffer.sv
// fetch_buffer: two-entry tagged prefetch FIFO of {addr, data}; entry 0 is always the head.
// Ports:
//   clk, clb              clock and asynchronous active-low reset
//   push, push_addr/data  append an entry into the next free slot
//   pop                   drop the head, shifting entry 1 forward
//   flush                 empty the buffer (overrides push and pop)
//   count                 number of valid entries (0..2)
//   head_addr, head_data  oldest entry
module fetch_buffer import fetch_pkg::*; #(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic          clk,
    input  logic          clb,
    input  logic          push,
    input  logic [AW-1:0] push_addr,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    input  logic          flush,
    output logic [1:0]    count,
    output logic [AW-1:0] head_addr,
    output logic [DW-1:0] head_data
);

    logic [AW-1:0] addr_q [2];
    logic [AW-1:0] addr_d [2];
    logic [DW-1:0] data_q [2];
    logic [DW-1:0] data_d [2];
    logic [1:0]    count_q;
    logic [1:0]    count_d;
    logic          wr_idx;

    // The free slot after an optional pop is count-pop; its low bit is enough
    // because a push into a full buffer without a pop never happens.
    assign wr_idx = count_q[0] ^ pop;

    always_comb begin
        addr_d = addr_q;
        data_d = data_q;
        if (pop) begin
            addr_d[0] = addr_q[1];
            data_d[0] = data_q[1];
        end
        if (push) begin
            addr_d[wr_idx] = push_addr;
            data_d[wr_idx] = push_data;
        end
        count_d = flush ? 2'd0 : count_q + {1'b0, push} - {1'b0, pop};
    end

    always_ff @(posedge clk or negedge clb) begin
        if (!clb) begin
            addr_q  <= '{default: '0};
            data_q  <= '{default: '0};
            count_q <= 2'd0;
        end else begin
            addr_q  <= addr_d;
            data_q  <= data_d;
            count_q <= count_d;
        end
    end

    assign count     = count_q;
    assign head_addr = addr_q[0];
    assign head_data = data_q[0];

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: sequential instruction prefetcher between a processor pc and program memory.
// Ports:
//   clk, clb            clock and asynchronous active-low reset
//   pc                  address the processor is executing
//   instruction         head data when instr_valid, else zero
//   instr_valid         buffered head matches pc
//   mem_req, mem_addr   registered read request to program memory
//   mem_ack, mem_rdata  same-cycle accept and read data
module fetch_unit import fetch_pkg::*; #(
    parameter int AW    = AW_DEF,
    parameter int DW    = DW_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic          clk,
    input  logic          clb,
    input  logic [AW-1:0] pc,
    output logic [DW-1:0] instruction,
    output logic          instr_valid,
    output logic          mem_req,
    output logic [AW-1:0] mem_addr,
    input  logic          mem_ack,
    input  logic [DW-1:0] mem_rdata
);

    localparam logic [1:0] FULL = 2'(DEPTH);
    localparam logic [1:0] LAST = 2'(DEPTH - 1);

    state_t        state_q;
    logic [AW-1:0] fptr_q;
    logic [AW-1:0] mem_addr_q;
    logic          mem_req_q;

    logic [1:0]    count;
    logic [AW-1:0] head_addr;
    logic [AW-1:0] head_next;
    logic [DW-1:0] head_data;
    logic [AW-1:0] pending;
    logic [1:0]    after_pop;
    logic          has, tag_hit, tag_next, pop, miss, push;

    assign has       = count != 2'd0;
    assign head_next = head_addr + AW'(1);
    assign tag_hit   = head_addr == pc;
    assign tag_next  = head_next == pc;
    assign pop       = has && tag_next;
    // With an empty buffer pc must match the address about to arrive.
    assign pending   = (state_q == WAIT) ? mem_addr_q : fptr_q;
    assign miss      = has ? !(tag_hit || tag_next) : (pc != pending);
    assign push      = (state_q == WAIT) && mem_ack && !miss;
    assign after_pop = count - {1'b0, pop};

    fetch_buffer #(.AW(AW), .DW(DW)) u_buf (
        .clk       (clk),
        .clb       (clb),
        .push      (push),
        .push_addr (mem_addr_q),
        .push_data (mem_rdata),
        .pop       (pop),
        .flush     (miss),
        .count     (count),
        .head_addr (head_addr),
        .head_data (head_data)
    );

    always_ff @(posedge clk or negedge clb) begin
        if (!clb) begin
            state_q    <= IDLE;
            fptr_q     <= '0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
        end else if (miss) begin
            fptr_q    <= pc;
            mem_req_q <= 1'b1;
            // An unacked request cannot be withdrawn, so it is drained in DROP;
            // otherwise the new address goes out on the next cycle.
            if (state_q != IDLE && !mem_ack) begin
                state_q <= DROP;
            end else begin
                state_q    <= WAIT;
                mem_addr_q <= pc;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (count < FULL) begin
                        state_q    <= WAIT;
                        mem_req_q  <= 1'b1;
                        mem_addr_q <= fptr_q;
                    end
                end
                WAIT: begin
                    if (mem_ack) begin
                        fptr_q <= fptr_q + AW'(1);
                        if (after_pop < LAST) begin
                            mem_addr_q <= fptr_q + AW'(1);
                        end else begin
                            state_q   <= IDLE;
                            mem_req_q <= 1'b0;
                        end
                    end
                end
                DROP: begin
                    if (mem_ack) begin
                        state_q    <= WAIT;
                        mem_addr_q <= fptr_q;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    mem_req_q <= 1'b0;
                end
            endcase
        end
    end

    assign mem_req     = mem_req_q;
    assign mem_addr    = mem_addr_q;
    assign instr_valid = has && tag_hit;
    assign instruction = instr_valid ? head_data : '0;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scoreboard bench for fetch_unit with a zero/controlled-wait ROM.
module tb_fetch_unit;

    logic       clk    = 1'b0;
    logic       clb    = 1'b1;
    logic       ack_en = 1'b1;
    logic [7:0] pc     = 8'h00;
    logic       mem_req, mem_ack, instr_valid;
    logic [7:0] mem_addr, mem_rdata, instruction;

    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   taken    = 0;
    int   xfers    = 0;
    int   t0, x0;

    function automatic logic [7:0] rom(input logic [7:0] a);
        return (a * 8'd7) ^ 8'h3C;
    endfunction

    assign mem_ack   = ack_en;
    assign mem_rdata = rom(mem_addr);

    fetch_unit dut (
        .clk         (clk),
        .clb         (clb),
        .pc          (pc),
        .instruction (instruction),
        .instr_valid (instr_valid),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: counts memory transfers and scores each presented instruction.
    initial forever begin
        @(negedge clk);
        if (clb && mem_req && mem_ack) xfers++;
        if (clb && instr_valid && exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check($sformatf("instr@%02h", mon_e.addr), instruction, mon_e.data);
            taken++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [7:0] a);
        pc = a;
        exp_q.push_back('{a, rom(a)});
    endtask

    task automatic await_take(input int t);
        for (int k = 0; k < 20 && taken == t; k++) @(posedge clk);
        if (taken == t) begin
            n_checks++;
            n_fail++;
            $display("FAIL take@%02h: no instr_valid within 20 cycles", pc);
            exp_q.delete();
        end
        #1;
    endtask

    task automatic step(input logic [7:0] a);
        int t;
        t = taken;
        present(a);
        await_take(t);
    endtask

    initial begin
        #2 clb = 1'b0;
        #1;
        check("rst_req", mem_req, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_valid", instr_valid, 0);
        check("rst_instr", instruction, 0);
        repeat (2) @(posedge clk);
        #1 clb = 1'b1;
        tick(1);
        check("boot_req", mem_req, 1);
        check("boot_addr", mem_addr, 8'h00);
        check("boot_valid", instr_valid, 0);
        tick(1);
        check("boot2_valid", instr_valid, 1);
        check("boot2_instr", instruction, rom(8'h00));
        check("boot2_addr", mem_addr, 8'h01);
        for (int i = 0; i < 4; i++) step(8'(i));
        check("pre_jump_req", mem_req, 1);
        check("pre_jump_addr", mem_addr, 8'h04);
        ack_en = 1'b0;
        pc     = 8'h40;
        tick(1);
        check("drop_req", mem_req, 1);
        check("drop_addr", mem_addr, 8'h04);
        check("drop_valid", instr_valid, 0);
        check("drop_instr", instruction, 0);
        ack_en = 1'b1;
        tick(1);
        check("jump_addr", mem_addr, 8'h40);
        check("jump_valid", instr_valid, 0);
        step(8'h40);
        tick(2);
        check("full_req", mem_req, 0);
        check("full_valid", instr_valid, 1);
        check("full_instr", instruction, rom(8'h40));
        x0 = xfers;
        step(8'h41);
        tick(3);
        check("pop_xfers", xfers - x0, 1);
        check("pop_req", mem_req, 0);
        check("pop_instr", instruction, rom(8'h41));
        ack_en = 1'b0;
        pc     = 8'h05;
        x0     = xfers;
        tick(1);
        check("stall_req0", mem_req, 1);
        check("stall_addr0", mem_addr, 8'h05);
        for (int i = 0; i < 3; i++) begin
            tick(1);
            check($sformatf("stall_req%0d", i + 1), mem_req, 1);
            check($sformatf("stall_addr%0d", i + 1), mem_addr, 8'h05);
            check($sformatf("stall_valid%0d", i + 1), instr_valid, 0);
        end
        check("stall_xfers", xfers - x0, 0);
        ack_en = 1'b1;
        step(8'h05);
        step(8'hFE);
        step(8'hFF);
        check("wrap_req", mem_req, 1);
        check("wrap_addr", mem_addr, 8'h00);
        t0 = taken;
        present(8'h00);
        tick(1);
        check("wrap_valid", instr_valid, 1);
        check("wrap_instr", instruction, rom(8'h00));
        check("wrap_next", mem_addr, 8'h01);
        await_take(t0);
        step(8'h01);
        check("pre_rst_req", mem_req, 1);
        clb = 1'b0;
        pc  = 8'h00;
        #1;
        check("mid_rst_req", mem_req, 0);
        check("mid_rst_addr", mem_addr, 0);
        check("mid_rst_valid", instr_valid, 0);
        check("mid_rst_instr", instruction, 0);
        tick(1);
        clb = 1'b1;
        tick(1);
        check("rel_req", mem_req, 1);
        check("rel_addr", mem_addr, 8'h00);
        check("rel_valid", instr_valid, 0);
        step(8'h00);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
